// File: rtl/cpu7_exu_wb_arb.sv
// Write-back arbiter: three requesters (ALU, LSU, MDU) share two register-file write ports.
// Round-robin selection with a starvation override on port 1, and a registered RF write stage.
module cpu7_exu_wb_arb #(
  parameter int DW         = 32,
  parameter int AW         = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  // Requester i transfers on a cycle where req_valid[i] & req_ready[i]; ready never waits on a transfer.
  input  logic [2:0]      req_valid,
  output logic [2:0]      req_ready,
  input  logic [3*AW-1:0] req_addr,
  input  logic [3*DW-1:0] req_data,
  output logic            wen1,
  output logic [AW-1:0]   waddr1,
  output logic [DW-1:0]   wdata1,
  output logic            wen2,
  output logic [AW-1:0]   waddr2,
  output logic [DW-1:0]   wdata2,
  output logic            starve_flag
);

  localparam int            CW      = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [1:0]         rr_ptr;
  logic [1:0]         rr_next;
  logic [2:0][CW-1:0] wait_cnt;
  logic [AW-1:0]      addr [3];
  logic [DW-1:0]      data [3];
  logic               sel_a_vld;
  logic               sel_b_vld;
  logic [1:0]         sel_a;
  logic [1:0]         sel_b;

  for (genvar i = 0; i < 3; i++) begin : g_unpack
    assign addr[i] = req_addr[i*AW +: AW];
    assign data[i] = req_data[i*DW +: DW];
  end

  function automatic logic [1:0] mod3_add(input logic [1:0] p, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, p} + {1'b0, k};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // Position of requester idx in the scan that starts at p.
  function automatic logic [1:0] scan_pos(input logic [1:0] idx, input logic [1:0] p);
    return mod3_add(idx, (p == 2'd0) ? 2'd0 : 2'(3'd3 - {1'b0, p}));
  endfunction

  always_comb begin
    logic [1:0] idx;
    idx         = 2'd0;
    sel_a_vld   = 1'b0;
    sel_a       = 2'd0;
    sel_b_vld   = 1'b0;
    sel_b       = 2'd0;
    starve_flag = 1'b0;
    req_ready   = 3'b000;
    if (!hold && !rst) begin
      for (int k = 0; k < 3; k++) begin
        idx = mod3_add(rr_ptr, 2'(k));
        if (!sel_a_vld && req_valid[idx] && wait_cnt[idx] == CNT_MAX) begin
          sel_a_vld   = 1'b1;
          sel_a       = idx;
          starve_flag = 1'b1;
        end
      end
      for (int k = 0; k < 3; k++) begin
        idx = mod3_add(rr_ptr, 2'(k));
        if (!sel_a_vld && req_valid[idx]) begin
          sel_a_vld = 1'b1;
          sel_a     = idx;
        end
      end
      // Port 2 continues the scan past grant A, skipping anyone targeting A's register.
      for (int k = 1; k < 3; k++) begin
        idx = mod3_add(sel_a, 2'(k));
        if (sel_a_vld && !sel_b_vld && req_valid[idx] && addr[idx] != addr[sel_a]) begin
          sel_b_vld = 1'b1;
          sel_b     = idx;
        end
      end
      if (sel_a_vld) req_ready[sel_a] = 1'b1;
      if (sel_b_vld) req_ready[sel_b] = 1'b1;
    end
  end

  always_comb begin
    rr_next = rr_ptr;
    if (sel_a_vld) begin
      if (sel_b_vld && scan_pos(sel_b, rr_ptr) > scan_pos(sel_a, rr_ptr)) begin
        rr_next = mod3_add(sel_b, 2'd1);
      end else begin
        rr_next = mod3_add(sel_a, 2'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= 2'd0;
      wait_cnt <= '0;
      wen1     <= 1'b0;
      waddr1   <= '0;
      wdata1   <= '0;
      wen2     <= 1'b0;
      waddr2   <= '0;
      wdata2   <= '0;
    end else begin
      rr_ptr <= rr_next;
      // r0 grants consume the slot but never write.
      wen1   <= sel_a_vld && (addr[sel_a] != '0);
      wen2   <= sel_b_vld && (addr[sel_b] != '0);
      if (sel_a_vld) begin
        waddr1 <= addr[sel_a];
        wdata1 <= data[sel_a];
      end
      if (sel_b_vld) begin
        waddr2 <= addr[sel_b];
        wdata2 <= data[sel_b];
      end
      for (int i = 0; i < 3; i++) begin
        if (!req_valid[i] || req_ready[i]) begin
          wait_cnt[i] <= '0;
        end else if (!hold && wait_cnt[i] != CNT_MAX) begin
          wait_cnt[i] <= wait_cnt[i] + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu7_exu_wb_arb.sv
// Bench for cpu7_exu_wb_arb: two instances (STARVE_MAX 4 and 1) share stimulus and are
// compared every cycle against a grant model built from the arbitration rules.
module tb_cpu7_exu_wb_arb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SMAX [2] = '{4, 1};

  logic            clk = 1'b0;
  logic            rst;
  logic            hold;
  logic [2:0]      req_valid;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_data;

  logic [2:0]    ready  [2];
  logic          wen1   [2];
  logic          wen2   [2];
  logic          sflag  [2];
  logic [AW-1:0] waddr1 [2];
  logic [AW-1:0] waddr2 [2];
  logic [DW-1:0] wdata1 [2];
  logic [DW-1:0] wdata2 [2];

  always #5 clk = ~clk;

  cpu7_exu_wb_arb #(.DW(DW), .AW(AW), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst), .hold(hold), .req_valid(req_valid), .req_ready(ready[0]),
    .req_addr(req_addr), .req_data(req_data),
    .wen1(wen1[0]), .waddr1(waddr1[0]), .wdata1(wdata1[0]),
    .wen2(wen2[0]), .waddr2(waddr2[0]), .wdata2(wdata2[0]),
    .starve_flag(sflag[0])
  );

  cpu7_exu_wb_arb #(.DW(DW), .AW(AW), .STARVE_MAX(1)) dut_s1 (
    .clk(clk), .rst(rst), .hold(hold), .req_valid(req_valid), .req_ready(ready[1]),
    .req_addr(req_addr), .req_data(req_data),
    .wen1(wen1[1]), .waddr1(waddr1[1]), .wdata1(wdata1[1]),
    .wen2(wen2[1]), .waddr2(waddr2[1]), .wdata2(wdata2[1]),
    .starve_flag(sflag[1])
  );

  // Reference model state, one copy per instance.
  int            m_rr    [2];
  int            m_wait  [2][3];
  int            m_a     [2];
  int            m_b     [2];
  logic [2:0]    e_ready [2];
  logic          e_starve[2];
  logic          e_wen1  [2];
  logic          e_wen2  [2];
  logic [AW-1:0] e_waddr1[2];
  logic [AW-1:0] e_waddr2[2];
  logic [DW-1:0] e_wdata1[2];
  logic [DW-1:0] e_wdata2[2];

  // Values observed at the most recent step, for scenario-specific checks.
  logic [2:0]    obs_ready [2];
  logic          obs_sflag [2];
  logic          obs_wen1  [2];
  logic          obs_wen2  [2];
  logic [AW-1:0] obs_waddr1[2];
  logic [AW-1:0] obs_waddr2[2];

  int n_vec = 0;
  int n_err = 0;
  int n_cmp = 0;

  function automatic logic [AW-1:0] addr_of(input int i);
    return req_addr[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] data_of(input int i);
    return req_data[i*DW +: DW];
  endfunction

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]         = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic model_grant(input int m);
    int order[$];
    int a;
    int b;
    a           = -1;
    b           = -1;
    e_starve[m] = 1'b0;
    if (!rst && !hold) begin
      for (int k = 0; k < 3; k++) order.push_back((m_rr[m] + k) % 3);
      foreach (order[k]) begin
        if (a < 0 && req_valid[order[k]] && m_wait[m][order[k]] >= SMAX[m]) begin
          a           = order[k];
          e_starve[m] = 1'b1;
        end
      end
      foreach (order[k]) if (a < 0 && req_valid[order[k]]) a = order[k];
      if (a >= 0) begin
        for (int k = 1; k < 3; k++) begin
          if (b < 0 && req_valid[(a + k) % 3] && addr_of((a + k) % 3) != addr_of(a)) b = (a + k) % 3;
        end
      end
    end
    m_a[m]     = a;
    m_b[m]     = b;
    e_ready[m] = 3'b000;
    if (a >= 0) e_ready[m][a] = 1'b1;
    if (b >= 0) e_ready[m][b] = 1'b1;
  endtask

  task automatic model_update(input int m);
    int last;
    if (rst) begin
      m_rr[m] = 0;
      for (int i = 0; i < 3; i++) m_wait[m][i] = 0;
      e_wen1[m]   = 1'b0;
      e_wen2[m]   = 1'b0;
      e_waddr1[m] = '0;
      e_waddr2[m] = '0;
      e_wdata1[m] = '0;
      e_wdata2[m] = '0;
    end else begin
      e_wen1[m] = (m_a[m] >= 0) && (addr_of(m_a[m]) != 0);
      e_wen2[m] = (m_b[m] >= 0) && (addr_of(m_b[m]) != 0);
      if (m_a[m] >= 0) begin
        e_waddr1[m] = addr_of(m_a[m]);
        e_wdata1[m] = data_of(m_a[m]);
      end
      if (m_b[m] >= 0) begin
        e_waddr2[m] = addr_of(m_b[m]);
        e_wdata2[m] = data_of(m_b[m]);
      end
      if (m_a[m] >= 0) begin
        last = -1;
        for (int k = 0; k < 3; k++) begin
          if ((m_rr[m] + k) % 3 == m_a[m] || (m_rr[m] + k) % 3 == m_b[m]) last = (m_rr[m] + k) % 3;
        end
        m_rr[m] = (last + 1) % 3;
      end
      for (int i = 0; i < 3; i++) begin
        if (!req_valid[i] || e_ready[m][i]) m_wait[m][i] = 0;
        else if (!hold && m_wait[m][i] < SMAX[m]) m_wait[m][i]++;
      end
    end
  endtask

  // One clock: compare both instances against the model at the falling edge, then advance.
  task automatic step();
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      model_grant(m);
      obs_ready[m]  = ready[m];
      obs_sflag[m]  = sflag[m];
      obs_wen1[m]   = wen1[m];
      obs_wen2[m]   = wen2[m];
      obs_waddr1[m] = waddr1[m];
      obs_waddr2[m] = waddr2[m];
      n_cmp += 8;
      if (ready[m] !== e_ready[m]) begin
        n_err++;
        $display("FAIL ready inst%0d t=%0t got %b want %b", m, $time, ready[m], e_ready[m]);
      end
      if (sflag[m] !== e_starve[m]) begin
        n_err++;
        $display("FAIL starve_flag inst%0d t=%0t got %b want %b", m, $time, sflag[m], e_starve[m]);
      end
      if (wen1[m] !== e_wen1[m] || wen2[m] !== e_wen2[m]) begin
        n_err++;
        $display("FAIL wen inst%0d t=%0t got %b%b want %b%b", m, $time, wen1[m], wen2[m], e_wen1[m], e_wen2[m]);
      end
      if (waddr1[m] !== e_waddr1[m]) begin
        n_err++;
        $display("FAIL waddr1 inst%0d t=%0t got %0d want %0d", m, $time, waddr1[m], e_waddr1[m]);
      end
      if (waddr2[m] !== e_waddr2[m]) begin
        n_err++;
        $display("FAIL waddr2 inst%0d t=%0t got %0d want %0d", m, $time, waddr2[m], e_waddr2[m]);
      end
      if (wdata1[m] !== e_wdata1[m]) begin
        n_err++;
        $display("FAIL wdata1 inst%0d t=%0t got %h want %h", m, $time, wdata1[m], e_wdata1[m]);
      end
      if (wdata2[m] !== e_wdata2[m]) begin
        n_err++;
        $display("FAIL wdata2 inst%0d t=%0t got %h want %h", m, $time, wdata2[m], e_wdata2[m]);
      end
      if (wen1[m] === 1'b1 && wen2[m] === 1'b1 && waddr1[m] === waddr2[m]) begin
        n_err++;
        $display("FAIL waddr_clash inst%0d t=%0t got %0d on both ports want distinct", m, $time, waddr1[m]);
      end
    end
    for (int m = 0; m < 2; m++) model_update(m);
    n_vec++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    hold = 1'b0;
    set_req(0, 1'b1, 5'd1, 32'h11);
    set_req(1, 1'b1, 5'd2, 32'h22);
    set_req(2, 1'b1, 5'd3, 32'h33);
    step();
    step();
    n_cmp++;
    if (obs_ready[0] !== 3'b000) begin
      n_err++;
      $display("FAIL reset_ready got %b want 000", obs_ready[0]);
    end
    rst       = 1'b0;
    req_valid = 3'b000;
    step();
    n_cmp++;
    if (obs_wen1[0] !== 1'b0 || obs_wen2[0] !== 1'b0) begin
      n_err++;
      $display("FAIL reset_wen got %b%b want 00", obs_wen1[0], obs_wen2[0]);
    end
  endtask

  task automatic test_all_valid();
    do_reset();
    set_req(0, 1'b1, 5'd5, $urandom);
    set_req(1, 1'b1, 5'd6, $urandom);
    set_req(2, 1'b1, 5'd7, $urandom);
    step();
    n_cmp++;
    if (obs_ready[0] !== 3'b011) begin
      n_err++;
      $display("FAIL all_valid_ready got %b want 011", obs_ready[0]);
    end
    step();
    n_cmp += 2;
    if (obs_wen1[0] !== 1'b1 || obs_waddr1[0] !== 5'd5 || obs_wen2[0] !== 1'b1 || obs_waddr2[0] !== 5'd6) begin
      n_err++;
      $display("FAIL all_valid_write got %b/%0d %b/%0d want 1/5 1/6",
               obs_wen1[0], obs_waddr1[0], obs_wen2[0], obs_waddr2[0]);
    end
    if (obs_ready[0] !== 3'b101) begin
      n_err++;
      $display("FAIL all_valid_rr2 got %b want 101", obs_ready[0]);
    end
  endtask

  task automatic test_same_addr();
    do_reset();
    set_req(0, 1'b1, 5'd9, 32'hA0A0_0001);
    set_req(1, 1'b1, 5'd9, 32'hB0B0_0002);
    set_req(2, 1'b0, 5'd9, 32'h0);
    step();
    n_cmp++;
    if (obs_ready[0] !== 3'b001) begin
      n_err++;
      $display("FAIL same_addr_ready got %b want 001", obs_ready[0]);
    end
    step();
    n_cmp += 2;
    if (obs_wen1[0] !== 1'b1 || obs_waddr1[0] !== 5'd9 || obs_wen2[0] !== 1'b0) begin
      n_err++;
      $display("FAIL same_addr_write got %b/%0d wen2=%b want 1/9 wen2=0", obs_wen1[0], obs_waddr1[0], obs_wen2[0]);
    end
    if (obs_ready[0] !== 3'b010) begin
      n_err++;
      $display("FAIL same_addr_lsu_next got %b want 010", obs_ready[0]);
    end
  endtask

  task automatic test_fairness();
    int gap;
    int max_gap;
    do_reset();
    set_req(0, 1'b1, 5'd1, $urandom);
    set_req(1, 1'b1, 5'd2, $urandom);
    set_req(2, 1'b1, 5'd3, $urandom);
    gap     = 0;
    max_gap = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (obs_ready[0][2] === 1'b1) gap = 0;
      else gap++;
      if (gap > max_gap) max_gap = gap;
      if (c == 1) begin
        n_cmp++;
        if (obs_sflag[1] !== 1'b1 || obs_ready[1][2] !== 1'b1) begin
          n_err++;
          $display("FAIL starve_override got flag=%b ready=%b want flag=1 ready[2]=1", obs_sflag[1], obs_ready[1]);
        end
      end
      if (c == 2) begin
        n_cmp++;
        if (obs_waddr1[1] !== 5'd3) begin
          n_err++;
          $display("FAIL starve_port1 got %0d want 3", obs_waddr1[1]);
        end
      end
    end
    n_cmp++;
    if (max_gap > 2) begin
      n_err++;
      $display("FAIL mdu_fairness got gap %0d want <= 2", max_gap);
    end
  endtask

  task automatic test_r0();
    do_reset();
    set_req(0, 1'b1, 5'd0, 32'hDEAD_BEEF);
    set_req(1, 1'b0, 5'd4, 32'h0);
    set_req(2, 1'b0, 5'd4, 32'h0);
    step();
    n_cmp++;
    if (obs_ready[0] !== 3'b001) begin
      n_err++;
      $display("FAIL r0_ready got %b want 001", obs_ready[0]);
    end
    req_valid = 3'b000;
    step();
    n_cmp++;
    if (obs_wen1[0] !== 1'b0 || obs_wen2[0] !== 1'b0) begin
      n_err++;
      $display("FAIL r0_wen got %b%b want 00", obs_wen1[0], obs_wen2[0]);
    end
  endtask

  task automatic test_hold();
    logic [2:0] pre;
    do_reset();
    set_req(0, 1'b1, 5'd4, $urandom);
    set_req(1, 1'b1, 5'd8, $urandom);
    set_req(2, 1'b1, 5'd12, $urandom);
    step();
    model_grant(0);
    pre  = e_ready[0];
    hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++;
      if (obs_ready[0] !== 3'b000) begin
        n_err++;
        $display("FAIL hold_ready cycle %0d got %b want 000", c, obs_ready[0]);
      end
      if (c > 0) begin
        n_cmp++;
        if (obs_wen1[0] !== 1'b0 || obs_wen2[0] !== 1'b0) begin
          n_err++;
          $display("FAIL hold_wen cycle %0d got %b%b want 00", c, obs_wen1[0], obs_wen2[0]);
        end
      end
    end
    hold = 1'b0;
    step();
    n_cmp++;
    if (obs_ready[0] !== pre) begin
      n_err++;
      $display("FAIL hold_release got %b want %b", obs_ready[0], pre);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst  = ($urandom_range(0, 49) == 0);
      hold = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < 3; i++) begin
        set_req(i, ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), $urandom);
      end
      step();
    end
    rst  = 1'b0;
    hold = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    hold      = 1'b0;
    req_valid = 3'b000;
    req_addr  = '0;
    req_data  = '0;
    for (int m = 0; m < 2; m++) model_update(m);
    @(posedge clk);
    #1;
    test_reset();
    test_all_valid();
    test_same_addr();
    test_fairness();
    test_r0();
    test_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
